// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer and its bench.
package tdc_pkg;

  localparam int TDC_MAX_TAPS = 256;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT_STOP,
    CAPTURE,
    DONE
  } tdc_state_e;

  function automatic int fine_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Zero-extension keeps the property intact, so narrower tap words can be passed in.
  function automatic logic is_thermo(input logic [TDC_MAX_TAPS-1:0] t);
    return ~|(t & (t + TDC_MAX_TAPS'(1)));
  endfunction

endpackage

// File: rtl/tdc_sync_edge.sv
// Two-flop synchronizer for the raw stop input, plus a rising-edge strobe.
module tdc_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: clears the delay line, launches start, counts coarse
// cycles until the synchronized stop edge, then samples fine code and bubble flag.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int NUM_TAPS       = 32,
  parameter int COARSE_W       = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CAPTURE_DLY    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int FINE_W        = fine_w(NUM_TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  output logic                start_out,
  input  logic                stop_in,
  input  logic [NUM_TAPS-1:0] taps_raw,
  input  logic [FINE_W-1:0]   fine_code,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0]   res_fine,
  output logic                res_timeout,
  output logic                res_bubble,
  output logic                busy
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CAP_W = $clog2(CAPTURE_DLY + 1);
  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CAP_W-1:0]    CAP_LAST    = CAP_W'(CAPTURE_DLY - 1);
  localparam logic [COARSE_W-1:0] TIMEOUT     = COARSE_W'(TIMEOUT_CYCLES);

  tdc_state_e          state_q, state_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [CAP_W-1:0]    cap_q, cap_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [COARSE_W-1:0] res_coarse_q, res_coarse_d;
  logic [FINE_W-1:0]   res_fine_q, res_fine_d;
  logic                res_timeout_q, res_timeout_d;
  logic                res_bubble_q, res_bubble_d;
  logic                stop_sync, stop_rise;

  tdc_sync_edge u_stop_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (stop_in),
    .sync_o (stop_sync),
    .rise_o (stop_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      cap_q         <= '0;
      coarse_q      <= '0;
      res_coarse_q  <= '0;
      res_fine_q    <= '0;
      res_timeout_q <= 1'b0;
      res_bubble_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      cap_q         <= cap_d;
      coarse_q      <= coarse_d;
      res_coarse_q  <= res_coarse_d;
      res_fine_q    <= res_fine_d;
      res_timeout_q <= res_timeout_d;
      res_bubble_q  <= res_bubble_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    cap_d         = cap_q;
    coarse_d      = coarse_q;
    res_coarse_d  = res_coarse_q;
    res_fine_d    = res_fine_q;
    res_timeout_d = res_timeout_q;
    res_bubble_d  = res_bubble_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = ARM;
          settle_d = '0;
        end
      end
      ARM: begin
        // Counter parks at its last value while a stale stop is still high.
        if (settle_q == SETTLE_LAST) begin
          if (!stop_sync) state_d = LAUNCH;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      LAUNCH: begin
        coarse_d = '0;
        state_d  = WAIT_STOP;
      end
      WAIT_STOP: begin
        if (stop_rise) begin
          res_coarse_d = coarse_q;
          cap_d        = '0;
          state_d      = CAPTURE;
        end else if (coarse_q == TIMEOUT) begin
          res_coarse_d  = TIMEOUT;
          res_fine_d    = '0;
          res_timeout_d = 1'b1;
          res_bubble_d  = 1'b0;
          state_d       = DONE;
        end else if (coarse_q != '1) begin
          coarse_d = coarse_q + COARSE_W'(1);
        end
      end
      CAPTURE: begin
        if (cap_q == CAP_LAST) begin
          res_fine_d    = fine_code;
          res_bubble_d  = ~is_thermo(TDC_MAX_TAPS'(taps_raw));
          res_timeout_d = 1'b0;
          state_d       = DONE;
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign start_out   = (state_q == LAUNCH) || (state_q == WAIT_STOP) || (state_q == CAPTURE);
  assign res_coarse  = res_coarse_q;
  assign res_fine    = res_fine_q;
  assign res_timeout = res_timeout_q;
  assign res_bubble  = res_bubble_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with hand-computed expectations.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, start_out, stop_in;
  logic [31:0] taps_raw;
  logic [4:0]  fine_code;
  logic        res_valid, res_ready;
  logic [15:0] res_coarse;
  logic [4:0]  res_fine;
  logic        res_timeout, res_bubble, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .start_out  (start_out),
    .stop_in    (stop_in),
    .taps_raw   (taps_raw),
    .fine_code  (fine_code),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_coarse (res_coarse),
    .res_fine   (res_fine),
    .res_timeout(res_timeout),
    .res_bubble (res_bubble),
    .busy       (busy)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req_valid = 1'b0; stop_in = 1'b0; res_ready = 1'b0;
    taps_raw = '0; fine_code = '0;
    step(2);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_start", 32'(start_out), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_coarse", 32'(res_coarse), 32'd0);
    chk("rst_fine", 32'(res_fine), 32'd0);
    chk("rst_flags", {30'd0, res_timeout, res_bubble}, 32'd0);
    rst = 1'b0;
    step();

    // Request, settle for 4 cycles, then launch.
    req_valid = 1'b1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("arm_start_low", 32'(start_out), 32'd0);
      chk("arm_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("launch_start", 32'(start_out), 32'd1);

    // Stop rise lands at coarse count 37; result 41 cycles after launch.
    taps_raw = 32'h0000_03FF; fine_code = 5'd10;
    step(36);
    stop_in = 1'b1;
    step(4);
    chk("n37_valid_early", 32'(res_valid), 32'd0);
    step();
    chk("n37_valid", 32'(res_valid), 32'd1);
    chk("n37_coarse", 32'(res_coarse), 32'd37);
    chk("n37_fine", 32'(res_fine), 32'd10);
    chk("n37_timeout", 32'(res_timeout), 32'd0);
    chk("n37_bubble", 32'(res_bubble), 32'd0);
    chk("n37_start", 32'(start_out), 32'd0);

    // Backpressure with stray stop pulses.
    for (int i = 0; i < 20; i++) begin
      stop_in = (i % 4) < 2;
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_coarse", 32'(res_coarse), 32'd37);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("bp_fine", 32'(res_fine), 32'd10);
    stop_in = 1'b0; res_ready = 1'b1; req_valid = 1'b1;
    step();
    chk("xfer_valid_drop", 32'(res_valid), 32'd0);
    chk("xfer_idle", 32'(req_ready), 32'd1);
    chk("xfer_busy", 32'(busy), 32'd0);
    res_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("req_after_xfer", 32'(busy), 32'd1);

    // Bubbled tap word; stop rise at count 1.
    step(4);
    chk("b_launch", 32'(start_out), 32'd1);
    taps_raw = 32'h0000_0F0F; fine_code = 5'd7; stop_in = 1'b1;
    step(4);
    chk("b_valid_early", 32'(res_valid), 32'd0);
    step();
    chk("b_valid", 32'(res_valid), 32'd1);
    chk("b_coarse", 32'(res_coarse), 32'd1);
    chk("b_fine", 32'(res_fine), 32'd7);
    chk("b_bubble", 32'(res_bubble), 32'd1);
    chk("b_timeout", 32'(res_timeout), 32'd0);
    consume();

    // Stop still high at request: hold in ARM until it falls.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_arm_start", 32'(start_out), 32'd0);
      step();
    end
    chk("hold_arm_busy", 32'(busy), 32'd1);
    stop_in = 1'b0;
    step();
    chk("hold_fall1", 32'(start_out), 32'd0);
    step();
    chk("hold_fall2", 32'(start_out), 32'd0);
    step();
    chk("hold_launch", 32'(start_out), 32'd1);
    taps_raw = 32'hFFFF_FFFF; fine_code = 5'd31; stop_in = 1'b1;
    step(5);
    chk("ones_valid", 32'(res_valid), 32'd1);
    chk("ones_coarse", 32'(res_coarse), 32'd1);
    chk("ones_fine", 32'(res_fine), 32'd31);
    chk("ones_bubble", 32'(res_bubble), 32'd0);
    stop_in = 1'b0;
    consume();

    // Timeout with no stop.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(4);
    chk("to_launch", 32'(start_out), 32'd1);
    step(1001);
    chk("to_valid_early", 32'(res_valid), 32'd0);
    chk("to_start_high", 32'(start_out), 32'd1);
    step();
    chk("to_valid", 32'(res_valid), 32'd1);
    chk("to_coarse", 32'(res_coarse), 32'd1000);
    chk("to_fine", 32'(res_fine), 32'd0);
    chk("to_timeout", 32'(res_timeout), 32'd1);
    chk("to_bubble", 32'(res_bubble), 32'd0);
    chk("to_start_low", 32'(start_out), 32'd0);
    consume();

    // Reset pulse mid-measurement.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(4);
    step(10);
    chk("rm_start_high", 32'(start_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_start", 32'(start_out), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_req_ready", 32'(req_ready), 32'd1);
    chk("rm_valid", 32'(res_valid), 32'd0);
    step();
    rst = 1'b0;
    stop_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid || busy) seen = 1'b1;
      step();
    end
    chk("rm_no_result", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the carry-chain TDC datapath: accepts a measurement request and clears the delay line. It then launches the chain's start edge and runs a coarse clock-cycle counter until the asynchronous stop arrives. After stop, it samples the encoded fine code plus a bubble check of the captured taps and returns one coarse+fine result over a valid/ready handshake. It sits between a host or command interface and the TDC datapath, which consists of the delay line, the stop-edge tap register and the thermometer encoder.

Parameters:
NUM_TAPS, 32, delay-line length; fine code width is $clog2(NUM_TAPS)
COARSE_W, 16, coarse counter width
SETTLE_CYCLES, 4, cycles start is held low before launch so the chain fully clears (>=1)
CAPTURE_DLY, 2, cycles waited after synchronized stop edge before sampling the fine code and taps (>=1)
TIMEOUT_CYCLES, 1000, coarse count at which a missing stop aborts the measurement (< 2**COARSE_W)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  measurement request
req_ready  out  1  high only in IDLE
start_out  out  1  drives the delay-line start input
stop_in  in  1  raw asynchronous stop, also clocks the tap register externally
taps_raw  in  NUM_TAPS  captured tap word from the TDC datapath
fine_code  in  $clog2(NUM_TAPS)  encoder output from the TDC datapath
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_coarse  out  COARSE_W  coarse cycle count
res_fine  out  $clog2(NUM_TAPS)  fine code
res_timeout  out  1  stop never arrived
res_bubble  out  1  taps_raw not a valid thermometer code
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, released synchronously by the clk domain): state IDLE. start_out=0, res_valid=0, res_coarse=0, res_fine=0, res_timeout=0, res_bubble=0, busy=0, req_ready=1. The synchronizer flops and counters clear to 0.
- Reset mid-measurement aborts immediately; no result is produced.
- stop_in passes through a 2-flop synchronizer plus an edge register; stop_rise = sync & ~prev.
- States:
  - IDLE: req_ready=1. req_valid&&req_ready moves to ARM and clears the settle counter.
  - ARM: start_out=0. The settle counter increments each cycle. Exit to LAUNCH when counter==SETTLE_CYCLES-1 and synchronized stop==0. If stop is still high, remain in ARM with the counter saturated.
  - LAUNCH: one cycle. start_out=1, coarse counter cleared to 0. Next state is WAIT_STOP.
  - WAIT_STOP: start_out=1. The coarse counter increments by 1 per cycle, saturating.
    - On stop_rise, latch coarse = current counter value and go to CAPTURE.
    - Else, when the counter reaches TIMEOUT_CYCLES, go to DONE with res_timeout=1, res_coarse=TIMEOUT_CYCLES, res_fine=0, res_bubble=0.
    - stop_rise in the same cycle as the timeout count wins: it is treated as a normal capture.
  - CAPTURE: start_out=1. Wait CAPTURE_DLY cycles, then register res_fine=fine_code and res_bubble=~is_thermo(taps_raw), with res_timeout=0. Go to DONE.
  - DONE: start_out=0, res_valid=1. Outputs are held stable until res_ready; the transfer happens on res_valid&&res_ready. The same cycle returns to IDLE with res_valid=0 next cycle. No new request is accepted in the transfer cycle.
- is_thermo(t): ones fill from bit 0 upward, t & (t+1) == 0. All-zeros and all-ones are valid.
- Further stop edges outside WAIT_STOP are ignored.
- The coarse value is the raw count; synchronizer-latency calibration happens downstream.
- Latency with no backpressure and stop at coarse count N: res_valid rises N+CAPTURE_DLY+2 cycles after LAUNCH.

Decomposition:
- Shared package tdc_pkg holds:
  - the state enum (IDLE, ARM, LAUNCH, WAIT_STOP, CAPTURE, DONE)
  - the FINE_W = $clog2(NUM_TAPS) helper
  - the is_thermo function, also reused by verification.
- One sub-module: tdc_sync_edge, which implements the 2-flop synchronizer with async active-high reset plus rising-edge detect.
- The FSM, counters and result registers stay in tdc_meas_ctrl.

Test Plan:
- Reset release, then a request. Required: req_ready=1 and start_out=0 for exactly 4 cycles, then start_out=1.
- stop_in rises so stop_rise occurs at coarse count 37, with taps_raw=32'h0000_03FF and fine_code=10. Required: res_valid with coarse=37, fine=10, timeout=0, bubble=0.
- No stop after launch. Required: at count 1000, res_valid with coarse=1000, fine=0, timeout=1, and start_out dropped.
- taps_raw=32'h0000_0F0F at capture. Required: res_bubble=1, and fine reports the encoder value unchanged.
- res_ready held low for 20 cycles. Required: outputs stable with res_valid=1 and req_ready=0; stop pulses during this time are ignored. Raising res_ready then returns the block to IDLE on the next cycle.
- stop_in held high at request time. Required: the block stays in ARM with start_out=0 until stop falls, then launches after settle.
- rst pulsed during WAIT_STOP. Required: start_out=0 and state IDLE immediately, with no res_valid pulse.
